// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
//
// Drives a 4-digit common-anode seven-segment display by time-multiplexing.
// A 16-bit hex value is held in a display register. The four nibbles are
// presented one at a time on numout to an external combinational
// 4-bit-to-7-segment decoder. The decoder's pattern (segin) is registered
// onto the segment pins together with the matching active-low anode enable,
// so segments and anodes always change on the same edge.
//
// A new value is captured on the load strobe into a pending register. It is
// only transferred to the display register at a frame boundary, which is the
// end of digit 3's slot. This means a frame never shows a mix of old and new
// digits. If several loads arrive before the boundary, only the last one is
// kept.
//
// Every digit slot begins with one blank cycle (all anodes off). This gives
// the segment lines time to settle on the next digit's pattern without the
// previous digit briefly showing it (ghosting).
//
// Compile-time option:
//   DISP_LZB_EN  - when defined, leading-zero blanking is enabled.
//                  Digit i (i = 3..1) is kept dark while nibbles i..3 of
//                  the displayed value are all zero. Digit 0 always lights.
//                  When undefined, all four digits light every frame.
//
// Parameters:
//   TICKS_PER_DIGIT - clock cycles per digit slot, legal range 2..2**20.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   value_in   in  16   value to display, [3:0] is the rightmost digit
//   load       in   1   one-cycle strobe capturing value_in
//   numout     out  4   nibble for the decoder (combinational from registers)
//   segin      in   7   active-low segment pattern returned by the decoder
//   seg_n      out  7   registered active-low segments to the pins
//   an_n       out  4   registered active-low anode enables, bit i = digit i
//   pending    out  1   a loaded value is waiting for the frame boundary
//   frame_tick out  1   one-cycle pulse when a pending value is committed
// ---------------------------------------------------------------------------
module display_scanner #(
    parameter int TICKS_PER_DIGIT = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic        load,
    output logic [3:0]  numout,
    input  logic [6:0]  segin,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        pending,
    output logic        frame_tick
);

    localparam logic [19:0] PRESC_MAX = 20'(TICKS_PER_DIGIT - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [19:0] presc_q,   presc_d;
    logic [1:0]  digit_q,   digit_d;
    logic [15:0] disp_q,    disp_d;
    logic [15:0] pend_q,    pend_d;
    logic        pending_q, pending_d;
    logic [6:0]  seg_q,     seg_d;
    logic [3:0]  an_q,      an_d;
    logic        ftick_q,   ftick_d;

    // -----------------------------------------------------------------------
    // Decoded helpers
    // -----------------------------------------------------------------------
    logic       term_cnt;     // last cycle of the current digit slot
    logic       frame_bnd;    // last cycle of digit 3, i.e. end of frame
    logic       commit;       // pending value moves to the display this edge
    logic       blank_cycle;  // first cycle of a slot: all anodes off
    logic [3:0] digit_sel;    // one-hot (active-high) of the current digit
    logic [3:0] lzb_dark;     // digits suppressed by leading-zero blanking

    assign term_cnt    = (presc_q == PRESC_MAX);
    assign frame_bnd   = term_cnt && (digit_q == 2'd3);
    assign commit      = frame_bnd && pending_q;
    assign blank_cycle = (presc_q == '0);

    // One-hot decode of the digit index, one comparator per anode.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit_sel
        assign digit_sel[gi] = (digit_q == 2'(gi));
    end

`ifdef DISP_LZB_EN
    // Digit i goes dark when it and every more-significant nibble are zero.
    // Evaluated from disp_q, the same register that feeds numout, so the
    // mask is aligned with the segment pattern being captured this cycle.
    assign lzb_dark[0] = 1'b0;
    for (genvar gi = 1; gi < 4; gi++) begin : g_lzb
        assign lzb_dark[gi] = (disp_q[15:4*gi] == '0);
    end
`else
    assign lzb_dark = 4'b0000;
`endif

    // -----------------------------------------------------------------------
    // Nibble select for the external decoder
    // -----------------------------------------------------------------------
    always_comb begin
        numout = disp_q[3:0];
        case (digit_q)
            2'd0: numout = disp_q[3:0];
            2'd1: numout = disp_q[7:4];
            2'd2: numout = disp_q[11:8];
            2'd3: numout = disp_q[15:12];
            default: numout = disp_q[3:0];
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        presc_d   = presc_q;
        digit_d   = digit_q;
        disp_d    = disp_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        seg_d     = segin;
        an_d      = 4'b1111;
        ftick_d   = 1'b0;

        // Prescaler and digit index
        if (term_cnt) begin
            presc_d = '0;
            digit_d = digit_q + 2'd1;
        end else begin
            presc_d = presc_q + 20'd1;
        end

        // Commit at the frame boundary uses the pre-edge pending register,
        // so a load arriving on the same cycle is not lost: it lands in
        // pend_q below and keeps pending set for the next boundary.
        if (commit) begin
            disp_d    = pend_q;
            pending_d = 1'b0;
            ftick_d   = 1'b1;
        end

        if (load) begin
            pend_d    = value_in;
            pending_d = 1'b1;
        end

        // Anodes follow the digit that numout is selecting this cycle, so
        // after registration seg_n and an_n refer to the same digit.
        if (!blank_cycle) begin
            an_d = ~(digit_sel & ~lzb_dark);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            digit_q   <= '0;
            disp_q    <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            seg_q     <= 7'b1111111;
            an_q      <= 4'b1111;
            ftick_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            digit_q   <= digit_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            ftick_q   <= ftick_d;
        end
    end

    assign seg_n      = seg_q;
    assign an_n       = an_q;
    assign pending    = pending_q;
    assign frame_tick = ftick_q;

endmodule
